pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It detects load-use hazards in ID, stretches the MEM stage while data memory is not ready, and squashes younger instructions when a taken branch or a jump resolves in MEM. It drives the PC enable and the enable/flush inputs of IF_ID, ID_EX, EX_MEM and MEM_WB. Flushing a pipeline register zeroes its control-signal fields.

## Interface
- MEM_TIMEOUT, default 255: maximum consecutive dmem wait cycles before `err_timeout` is raised.
- CNT_W, default 32: width of the performance counters.

- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  5  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the instruction in ID reads rs1 / rs2
- ex_memRead  in  1  memRead_out of ID_EX
- ex_rd  in  5  rd_out of ID_EX
- mem_redirect  in  1  taken branch or jump resolved in MEM
- mem_dmem_req  in  1  memRead_out | memWrite_out of EX_MEM
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  pipeline register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load a bubble instead of stage data
- pc_redirect  out  1  select the branch/jump target for the PC
- err_timeout  out  1  sticky flag: dmem wait exceeded MEM_TIMEOUT
- stall_cnt, flush_cnt  out  CNT_W  present only when the macro is set; see Configuration

## Operation
- FSM states: RUN, MEM_WAIT.
- Per-cycle conditions:
  - `lu` = ex_memRead & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - `mw` = mem_dmem_req & ~dmem_ready.
- Response priority, highest first:
  1. mw (any state): freeze. pc_en, if_id_en, id_ex_en, ex_mem_en = 0. mem_wb_en = 1 with mem_wb_flush = 1. mem_redirect is ignored this cycle.
  2. mem_redirect: pc_redirect = 1; if_id_flush, id_ex_flush, ex_mem_flush = 1; all enables = 1. lu is ignored.
  3. lu: pc_en = 0 and if_id_en = 0. id_ex_flush = 1, inserting one bubble. Downstream enables = 1.
  4. Otherwise: all enables = 1, no flush.
- Transitions:
  - RUN → MEM_WAIT on mw.
  - MEM_WAIT → RUN when dmem_ready. That cycle takes responses 2–4 normally, so a held redirect takes effect on the completing cycle.
- Wait counter:
  - Counts consecutive MEM_WAIT cycles and saturates at MEM_TIMEOUT.
  - Reaching MEM_TIMEOUT sets err_timeout. err_timeout clears only on reset.
  - The counter clears on return to RUN.
- A flush overrides stage data, but the register is still loaded (its en = 1) whenever its flush = 1.

## Timing
- All outputs except err_timeout and the counters are combinational from the state and the current inputs. There is zero latency from hazard to response.
- The FSM, wait counter and err_timeout update on posedge clk.
- A load-use hazard costs exactly 1 bubble.
- A redirect costs 3 squashed slots.
- A dmem wait of N not-ready cycles costs N bubbles into WB.
- While rst_n = 0:
  - pc_en and all *_en = 1, and all *_flush = 1, so the pipeline fills with bubbles.
  - pc_redirect = 0 and err_timeout = 0.
  - Counters = 0, state = RUN, wait counter = 0.
- Reset mid-wait: the next cycle after release is RUN with no residual stall.
- Boundary cases:
  - ex_rd = x0 never stalls.
  - lu and mw together: mw wins. lu is re-evaluated after the freeze, so exactly one bubble still results.

## Configuration
- PIPE_PERF_CNT_EN:
  - Defined: stall_cnt and flush_cnt ports exist.
    - stall_cnt increments on every cycle with lu or mw asserted.
    - flush_cnt increments on every cycle in which the redirect response (priority 2) is applied.
    - Both wrap at 2^CNT_W and clear on reset.
  - Undefined: ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `pipe_pkg`:
  - typedef `hz_state_t` (RUN, MEM_WAIT).
  - Struct `stage_ctl_t` {en, flush}.
  - Constant REG_X0 = 5'd0.
- Natural sub-module: `load_use_detect` (pure combinational `lu` compare). The FSM and counters stay in the top.

## Test plan
- lw x5 in EX, add with rs1 = x5 in ID → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; the next cycle has no stall.
- Load writes rd = x0, ID reads x0 → no stall; all enables = 1.
- mem_redirect = 1 with lu = 1 the same cycle → pc_redirect = 1, three flushes, pc_en = 1, and no stall.
- dmem_ready low for 3 cycles with mem_redirect = 1:
  - 3 freeze cycles, each with mem_wb_flush = 1.
  - Redirect applied on the 4th cycle.
  - State is back to RUN.
- MEM_TIMEOUT = 4, dmem_ready held low for 6 cycles → err_timeout rises after the 4th wait cycle and stays high after ready returns; a reset pulse clears it.
- With PIPE_PERF_CNT_EN: 2 load-use stalls plus 1 redirect → stall_cnt = 2, flush_cnt = 1; reset asserted mid-sequence → both counters 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam stage_ctl_t CTL_PASS   = '{en: 1'b1, flush: 1'b0};
  localparam stage_ctl_t CTL_HOLD   = '{en: 1'b0, flush: 1'b0};
  localparam stage_ctl_t CTL_BUBBLE = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_memRead,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign lu = ex_memRead && (ex_rd != REG_X0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) ||
               (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Define PIPE_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_redirect,
  input  logic             mem_dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             pc_redirect,
  output logic             err_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              err_q;
  logic              lu, mw;
  stage_ctl_t        if_id_c, id_ex_c, ex_mem_c, mem_wb_c;

  load_use_detect u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_memRead (ex_memRead),
    .ex_rd      (ex_rd),
    .lu         (lu)
  );

  assign mw = mem_dmem_req && !dmem_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
    state_nxt   = state;
    wait_nxt    = '0;
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    if_id_c     = CTL_PASS;
    id_ex_c     = CTL_PASS;
    ex_mem_c    = CTL_PASS;
    mem_wb_c    = CTL_PASS;

    unique case (state)
      RUN:      if (mw)         state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_ready) state_nxt = RUN;
      default:                  state_nxt = RUN;
    endcase

    if (state_nxt == MEM_WAIT)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);

    if (!rst_n) begin
      // Clock bubbles through every stage while reset is held.
      if_id_c  = CTL_BUBBLE;
      id_ex_c  = CTL_BUBBLE;
      ex_mem_c = CTL_BUBBLE;
      mem_wb_c = CTL_BUBBLE;
    end else if (mw) begin
      pc_en    = 1'b0;
      if_id_c  = CTL_HOLD;
      id_ex_c  = CTL_HOLD;
      ex_mem_c = CTL_HOLD;
      mem_wb_c = CTL_BUBBLE;
    end else if (mem_redirect) begin
      pc_redirect = 1'b1;
      if_id_c     = CTL_BUBBLE;
      id_ex_c     = CTL_BUBBLE;
      ex_mem_c    = CTL_BUBBLE;
    end else if (lu) begin
      pc_en   = 1'b0;
      if_id_c = CTL_HOLD;
      id_ex_c = CTL_BUBBLE;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      err_q    <= err_q || (wait_nxt == WAIT_MAX);
    end
  end

  assign err_timeout  = err_q && rst_n;
  assign if_id_en     = if_id_c.en;
  assign if_id_flush  = if_id_c.flush;
  assign id_ex_en     = id_ex_c.en;
  assign id_ex_flush  = id_ex_c.flush;
  assign ex_mem_en    = ex_mem_c.en;
  assign ex_mem_flush = ex_mem_c.flush;
  assign mem_wb_en    = mem_wb_c.en;
  assign mem_wb_flush = mem_wb_c.flush;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (lu || mw)            stall_q <= stall_q + CNT_W'(1);
      if (mem_redirect && !mw) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt = rst_n ? stall_q : '0;
  assign flush_cnt = rst_n ? flush_q : '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, corner sequences, random vs. reference model.
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  // Output vector order: pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect
  localparam logic [9:0] O_NONE = 10'b11111_0000_0;
  localparam logic [9:0] O_LU   = 10'b00111_0100_0;
  localparam logic [9:0] O_RED  = 10'b11111_1110_1;
  localparam logic [9:0] O_MW   = 10'b00001_0001_0;
  localparam logic [9:0] O_RST  = 10'b11111_1111_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_use_rs1, id_use_rs2, ex_memRead, mem_redirect, mem_dmem_req, dmem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect, err_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_memRead   (ex_memRead),
    .ex_rd        (ex_rd),
    .mem_redirect (mem_redirect),
    .mem_dmem_req (mem_dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_en     (id_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .pc_redirect  (pc_redirect),
    .err_timeout  (err_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

`ifndef PIPE_PERF_CNT_EN
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  wire [9:0] outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_redirect};

  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2;
    logic       u1, u2, mrd;
    logic [4:0] rd;
    logic       redir, req, rdy;
  } vin_t;

  typedef struct {
    vin_t       v;
    logic [9:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: in a dmem wait, length of the current wait, sticky error, perf counts.
  bit          m_wait;
  int          m_cnt;
  bit          m_err;
  logic [31:0] m_stall, m_flush;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vin_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic u1, input logic u2, input logic mrd, input logic [4:0] rd,
                              input logic redir, input logic req, input logic rdy);
    vin_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.mrd = mrd; v.rd = rd; v.redir = redir; v.req = req; v.rdy = rdy;
    return v;
  endfunction

  function automatic bit m_lu(input vin_t v);
    return v.mrd && (v.rd != 5'd0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
  endfunction

  function automatic bit m_mw(input vin_t v);
    return v.req && !v.rdy;
  endfunction

  function automatic logic [9:0] model_out(input vin_t v);
    if (!v.rst)   return O_RST;
    if (m_mw(v))  return O_MW;
    if (v.redir)  return O_RED;
    if (m_lu(v))  return O_LU;
    return O_NONE;
  endfunction

  function automatic void model_step(input vin_t v);
    bit waiting;
    if (!v.rst) begin
      m_wait = 0; m_cnt = 0; m_err = 0; m_stall = '0; m_flush = '0;
    end else begin
      waiting = m_wait ? !v.rdy : m_mw(v);
      if (waiting) begin
        if (m_cnt < TMO) m_cnt++;
        if (m_cnt == TMO) m_err = 1;
      end else begin
        m_cnt = 0;
      end
      m_wait = waiting;
      if (m_lu(v) || m_mw(v))  m_stall = m_stall + 32'd1;
      if (v.redir && !m_mw(v)) m_flush = m_flush + 32'd1;
    end
  endfunction

  task automatic drive(input vin_t v);
    rst_n = v.rst; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_memRead = v.mrd; ex_rd = v.rd; mem_redirect = v.redir;
    mem_dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  // One clock: drive at negedge, check combinational outputs, then check registered state after posedge.
  task automatic cycle(input string tag, input vin_t v, input logic [9:0] exp);
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".out"}, 64'(outs), 64'(exp));
    @(posedge clk);
    model_step(v);
    #1;
    check({tag, ".err"}, 64'(err_timeout), 64'(m_err));
`ifdef PIPE_PERF_CNT_EN
    check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
  endtask

  function automatic vin_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vin_t rst_v();
    return mk(0, 5, 5, 1, 1, 1, 5, 1, 1, 0);
  endfunction

  vec_t tbl[12];

  initial begin
    m_wait = 0; m_cnt = 0; m_err = 0; m_stall = '0; m_flush = '0;
    drive(rst_v());

    tbl[0]  = '{mk(1, 5, 7, 1, 1, 1, 5, 0, 0, 0), O_LU};   // lw x5; add uses rs1=x5
    tbl[1]  = '{mk(1, 2, 9, 1, 1, 1, 9, 0, 0, 0), O_LU};   // match on rs2
    tbl[2]  = '{mk(1, 2, 9, 1, 0, 1, 9, 0, 0, 0), O_NONE}; // rs2 matches but unused
    tbl[3]  = '{mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0), O_NONE}; // load to x0 never stalls
    tbl[4]  = '{mk(1, 5, 5, 1, 1, 0, 5, 0, 0, 0), O_NONE}; // not a load
    tbl[5]  = '{mk(1, 3, 4, 1, 1, 1, 6, 0, 0, 0), O_NONE}; // no register match
    tbl[6]  = '{mk(1, 5, 0, 1, 0, 1, 5, 1, 0, 0), O_RED};  // redirect beats load-use
    tbl[7]  = '{mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_RED};  // redirect with completing access
    tbl[8]  = '{mk(1, 5, 0, 1, 0, 1, 5, 1, 1, 0), O_MW};   // dmem wait beats everything
    tbl[9]  = '{mk(1, 5, 0, 1, 0, 1, 5, 0, 1, 1), O_LU};   // wait ends, load-use re-evaluated
    tbl[10] = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE}; // access completes at once
    tbl[11] = '{mk(0, 5, 0, 1, 0, 1, 5, 1, 1, 0), O_RST};  // reset forces bubbles everywhere

    // Reset state
    cycle("reset0", rst_v(), O_RST);
    cycle("reset1", rst_v(), O_RST);
    check("reset.state", 64'(dut.state), 64'(RUN));

    foreach (tbl[i]) cycle($sformatf("tbl%0d", i), tbl[i].v, tbl[i].exp);

    // Load-use costs exactly one bubble; the bubble then sits in EX
    cycle("lu.hit",  mk(1, 5, 7, 1, 1, 1, 5, 0, 0, 0), O_LU);
    cycle("lu.next", mk(1, 5, 7, 1, 1, 0, 0, 0, 0, 0), O_NONE);

    // Three not-ready cycles with a held redirect, redirect applied on the completing cycle
    for (int i = 0; i < 3; i++) begin
      cycle($sformatf("wred.freeze%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0), O_MW);
      check($sformatf("wred.state%0d", i), 64'(dut.state), 64'(MEM_WAIT));
    end
    cycle("wred.done", mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1), O_RED);
    check("wred.state_run", 64'(dut.state), 64'(RUN));

    // Timeout: err rises after the 4th wait cycle, survives ready, clears on reset
    cycle("tmo.rst", rst_v(), O_RST);
    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("tmo.wait%0d", i), mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_MW);
      check($sformatf("tmo.flag%0d", i), 64'(err_timeout), 64'(i >= TMO - 1));
    end
    cycle("tmo.ready", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE);
    check("tmo.sticky", 64'(err_timeout), 64'(1));
    cycle("tmo.clear", rst_v(), O_RST);
    check("tmo.cleared", 64'(err_timeout), 64'(0));

    // Reset in the middle of a wait leaves no residual stall
    cycle("rmw.w0", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_MW);
    cycle("rmw.w1", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_MW);
    cycle("rmw.rst", rst_v(), O_RST);
    cycle("rmw.after", idle(), O_NONE);
    check("rmw.state", 64'(dut.state), 64'(RUN));
    check("rmw.wait_cnt", 64'(dut.wait_cnt), 64'(0));

`ifdef PIPE_PERF_CNT_EN
    // Two load-use stalls plus one redirect, then reset mid-sequence
    cycle("perf.rst", rst_v(), O_RST);
    cycle("perf.lu0", mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0), O_LU);
    cycle("perf.nop", idle(), O_NONE);
    cycle("perf.lu1", mk(1, 0, 6, 0, 1, 1, 6, 0, 0, 0), O_LU);
    cycle("perf.red", mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), O_RED);
    check("perf.stall2", 64'(stall_cnt), 64'(2));
    check("perf.flush1", 64'(flush_cnt), 64'(1));
    cycle("perf.lu2", mk(1, 5, 0, 1, 0, 1, 5, 0, 0, 0), O_LU);
    cycle("perf.mid_rst", rst_v(), O_RST);
    check("perf.stall0", 64'(stall_cnt), 64'(0));
    check("perf.flush0", 64'(flush_cnt), 64'(0));
`endif

    // Randomized traffic against the reference model
    cycle("rnd.rst", rst_v(), O_RST);
    for (int i = 0; i < 800; i++) begin
      vin_t v;
      v = mk(($urandom_range(0, 63) != 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0),
             1'($urandom), ($urandom_range(0, 9) < 4));
      cycle($sformatf("rnd%0d", i), v, model_out(v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
